alu_seq: RTL and testbench

Parametrised, handshaked successor to the 32-bit combinational ALU (yAlu). Keeps the AND/OR/ADD/SUB/SLT op encoding and zero flag. Adds:
- shifts, a signed-overflow flag and an iterative multiplier;
- valid/ready handshakes on input and output, with a registered result.
Sits between operand fetch and writeback in the multi-cycle datapath.

---
 rtl/alu_pkg.sv | 18 +
 rtl/seq_mul.sv | 51 +++++
 rtl/alu_seq.sv | 121 ++++++++++++
 tb/tb_alu_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op encodings and controller state type for alu_seq
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - shift-add multiplier, one partial product per clock, low WIDTH bits
module seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = mplier[0] ? acc + mcand : acc;

  // done and p reflect the final step so the caller can load them on that same edge
  assign done = busy && (cnt == CW'(WIDTH - 1));
  assign p    = acc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered result, flags and iterative multiply
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);

  state_t           state;
  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_p;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SW-1:0]    shamt;
  logic             lt;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic             res_err;

  // rst_n gates in_ready so nothing is handshaken while reset is held
  assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (op == OP_MUL);

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SW-1:0];
  assign lt    = $signed(a) < $signed(b);

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    res_err = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD: begin
        res     = sum;
        res_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res     = diff;
        res_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: res = {{(WIDTH-1){1'b0}}, lt};
      OP_SLL: res = a << shamt;
      OP_SRL: res = a >> shamt;
      default: res_err = 1'b1;
    endcase
  end

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_mul),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      z         <= '0;
      zero      <= 1'b1;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state     <= BUSY;
              out_valid <= 1'b0;
            end else begin
              z         <= res;
              zero      <= (res == '0);
              ovf       <= res_ovf;
              err       <= res_err;
              out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (mul_done) begin
            z         <= mul_p;
            zero      <= (mul_p == '0);
            ovf       <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (MUL_EN=1 and MUL_EN=0 instances)
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = 3'b000;

  logic         in_ready, out_valid, zero, ovf, err;
  logic [W-1:0] z;
  logic         in_ready0, out_valid0, zero0, ovf0, err0;
  logic [W-1:0] z0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .zero(zero), .ovf(ovf), .err(err)
  );

  alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .op(op), .out_valid(out_valid0), .out_ready(out_ready),
    .z(z0), .zero(zero0), .ovf(ovf0), .err(err0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
    step(); step();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++;
    if ({out_valid, zero, ovf, err} !== 4'b0100 || z !== 32'd0) begin
      errors++; $display("FAIL reset_state got v=%b zero=%b ovf=%b err=%b z=%h exp v=0 zero=1 ovf=0 err=0 z=0", out_valid, zero, ovf, err, z);
    end
    in_valid = 1'b0; rst_n = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_stream();
    logic [2:0]   ops [3];
    logic [W-1:0] as  [3];
    logic [W-1:0] bs  [3];
    ops[0] = OP_ADD; as[0] = 32'd7;        bs[0] = 32'hFFFF_FFF9;
    ops[1] = OP_SUB; as[1] = 32'd5;        bs[1] = 32'd5;
    ops[2] = OP_AND; as[2] = 32'hF0F0_F0F0; bs[2] = 32'h0F0F_0F0F;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op = ops[i]; a = as[i]; b = bs[i]; in_valid = 1'b1; #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); end
      step();
      checks++;
      if (out_valid !== 1'b1 || z !== 32'd0 || zero !== 1'b1) begin
        errors++; $display("FAIL stream_result[%0d] got v=%b z=%h zero=%b exp v=1 z=0 zero=1", i, out_valid, z, zero);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_flags();
    logic [2:0]   ops [3];
    logic [W-1:0] as  [3];
    logic [W-1:0] bs  [3];
    logic [W-1:0] ez  [3];
    logic         eo  [3];
    ops[0] = OP_ADD; as[0] = 32'h7FFF_FFFF; bs[0] = 32'd1; ez[0] = 32'h8000_0000; eo[0] = 1'b1;
    ops[1] = OP_SUB; as[1] = 32'h8000_0000; bs[1] = 32'd1; ez[1] = 32'h7FFF_FFFF; eo[1] = 1'b1;
    ops[2] = OP_SLT; as[2] = 32'hFFFF_FFFF; bs[2] = 32'd0; ez[2] = 32'd1;         eo[2] = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op = ops[i]; a = as[i]; b = bs[i]; in_valid = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || z !== ez[i] || ovf !== eo[i] || zero !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL flags[%0d] got v=%b z=%h ovf=%b zero=%b err=%b exp v=1 z=%h ovf=%b zero=0 err=0",
                           i, out_valid, z, ovf, zero, err, ez[i], eo[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_mul();
    int n;
    int early;
    out_ready = 1'b1; op = OP_MUL; a = 32'hFFFF_FFFD; b = 32'd7; in_valid = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_accept_ready got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    n = 0; early = 0;
    while (in_ready === 1'b0 && n < 40) begin
      if (out_valid !== 1'b0) early++;
      n++;
      step();
    end
    checks++;
    if (n !== 32) begin errors++; $display("FAIL mul_busy_cycles got %0d exp 32", n); end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL mul_early_valid got %0d exp 0", early); end
    checks++;
    if (out_valid !== 1'b1 || z !== 32'hFFFF_FFEB || zero !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL mul_result got v=%b z=%h zero=%b ovf=%b exp v=1 z=ffffffeb zero=0 ovf=0", out_valid, z, zero, ovf);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int bad;
    out_ready = 1'b0; op = OP_ADD; a = 32'd2; b = 32'd3; in_valid = 1'b1;
    step();
    op = OP_OR; a = 32'd1; b = 32'd2;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || z !== 32'd5 || in_ready !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL backpressure_hold got %0d bad cycles exp 0 (z=%h)", bad, z); end
    out_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL backpressure_release_ready got %b exp 1", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b1 || z !== 32'd3) begin
      errors++; $display("FAIL backpressure_next got v=%b z=%h exp v=1 z=3", out_valid, z);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_shift_err();
    int n;
    out_ready = 1'b1; in_valid = 1'b1;
    op = OP_SLL; a = 32'd1; b = 32'h25;
    step();
    checks++;
    if (out_valid !== 1'b1 || z !== 32'h20) begin errors++; $display("FAIL sll got v=%b z=%h exp v=1 z=20", out_valid, z); end
    op = OP_SRL; a = 32'h8000_0000; b = 32'd31;
    step();
    checks++;
    if (out_valid !== 1'b1 || z !== 32'd1) begin errors++; $display("FAIL srl got v=%b z=%h exp v=1 z=1", out_valid, z); end
    op = OP_MUL; a = 32'd5; b = 32'd6;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid0, err0, zero0, ovf0} !== 4'b1110 || z0 !== 32'd0) begin
      errors++; $display("FAIL illegal_op got v=%b err=%b zero=%b ovf=%b z=%h exp v=1 err=1 zero=1 ovf=0 z=0", out_valid0, err0, zero0, ovf0, z0);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin n++; step(); end
    checks++;
    if (out_valid !== 1'b1 || z !== 32'd30 || err !== 1'b0) begin
      errors++; $display("FAIL mul_en_5x6 got v=%b z=%h err=%b exp v=1 z=1e err=0", out_valid, z, err);
    end
    step();
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    out_ready = 1'b1; op = OP_MUL; a = 32'hFFFF_FFFD; b = 32'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst_n = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midmul_reset_ready got %b exp 0", in_ready); end
    step();
    rst_n = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0 || z !== 32'd0 || zero !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midmul_after_reset got v=%b z=%h zero=%b rdy=%b exp v=0 z=0 zero=1 rdy=1", out_valid, z, zero, in_ready);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midmul_no_result got %0d valid cycles exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_flags();
    test_mul();
    test_back_to_back();
    test_shift_err();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
